plic_core_mt: RTL
=================

Name: plic_core_mt

Overview:
- Parametrised successor to the single-target PLIC core.
- Provides NSRC interrupt gateways with edge or level mode, per source. Edge mode counts pending edges up to a saturating limit.
- Runs one registered priority arbiter per target context (NTGT hart contexts), each with its own enable mask, threshold and claim/complete handshake.
- Sits between the memory-mapped PLIC register file and the hart external-interrupt inputs.

Parameters:
- NSRC, 15: number of interrupt sources; IDs are 1..NSRC, and ID 0 means "none".
- PRIO_W, 3: priority width; priority 0 means never interrupt.
- NTGT, 2: number of target contexts.
- MAX_EDGE, 3: saturation value of the per-source edge counter, minimum 1.
- IDW, $clog2(NSRC+1): ID width, derived; do not override.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  synchronous, active-high reset.
- src  in  NSRC  interrupt lines, already synchronous to clk.
- el  in  NSRC  per-source mode: 1 = edge, 0 = level.
- ipriority  in  NSRC*PRIO_W  source s priority at bits [s*PRIO_W +: PRIO_W].
- ie  in  NTGT*NSRC  enable mask of target t at bits [t*NSRC +: NSRC].
- threshold  in  NTGT*PRIO_W  threshold of target t.
- claim  in  NTGT  one-cycle claim strobe per target.
- complete  in  NTGT  one-cycle complete strobe per target.
- complete_id  in  NTGT*IDW  ID being completed by target t.
- ireq  out  NTGT  interrupt request per target; registered.
- id  out  NTGT*IDW  highest-priority eligible ID per target; registered.

Behaviour:
- Reset:
  - All gateways go to IDLE; edge counters and the src-delay register go to 0.
  - All id outputs = 0 and all ireq outputs = 0.
  - Reset asserted mid-operation discards every pending, claimed and counted interrupt.
- Gateway state machine per source (IDLE/PEND/BUSY):
  - ip = (state == PEND).
  - Level mode: IDLE→PEND when src=1. PEND→BUSY on claim. BUSY→IDLE on complete. If src is still 1 on return to IDLE, the source re-pends one cycle later.
  - Level mode: src deasserting while in PEND does not clear ip.
  - Edge mode: a rising edge (src & ~src_q) increments the counter, saturating at MAX_EDGE.
  - Edge mode: IDLE with cnt>0 → PEND and the counter decrements in that same cycle. An edge arriving in that same cycle is still counted, so the net count is unchanged.
  - Edges arriving in PEND or BUSY are counted and never lost below saturation.
- Arbitration, per target t, evaluated each cycle:
  - A source is eligible when ip=1, ie[t]=1, priority > threshold[t], and it is not being claimed this cycle by any target.
  - The winner is the highest priority; ties go to the lowest ID.
  - The winner is registered into id[t]. ireq[t] is registered as (winner != 0).
- Latency (level source, IDLE, enabled, priority above threshold):
  - src seen high at edge k → ip=1 after edge k.
  - id/ireq valid after edge k+1 (one-cycle arbiter register).
- Claim:
  - claim[t] claims the ID currently shown on id[t]. With id[t]=0 it has no effect.
  - If several targets claim the same ID in one cycle, the lowest-index target wins.
  - In the next cycle, each losing target's id shows its next eligible candidate, or 0 if none.
  - The claimed source is masked from all arbiters in the claim cycle. id[t] therefore never shows a stale claimed ID after the claim edge.
- Complete:
  - Honoured only when complete_id[t] is in 1..NSRC and that source is in BUSY. Otherwise it is silently ignored: ID 0, out-of-range ID, source not BUSY.
  - If two targets complete the same source in one cycle, the result is a single BUSY→IDLE transition.
- A mode change (el) while a source is not IDLE takes effect on its next IDLE entry. The counter is not cleared.
- No combinational path from any input to ireq or id.

Decomposition:
- Package plic_pkg:
  - gateway state enum (IDLE=2'd0, PEND=2'd1, BUSY=2'd2).
  - function clog2 for IDW.
  - helper function for per-target slice offsets.
- Sub-module plic_gateway_mt:
  - one per source (generate loop).
  - ports: clk, rst, src, el, claim, complete, ip.
  - contains the state machine, edge detect and saturating counter; parameter MAX_EDGE.
- Arbiter, claim-resolution and complete decode stay in the top level (generate loop over targets).

Test Plan (NSRC=15, PRIO_W=3, NTGT=2, MAX_EDGE=3):
- Level priority and latency: src3=1, prio3=5, ie0[3]=1, thr0=2 → ireq0=1, id0=3 two cycles after src rises; target 1 (ie1=0) keeps id1=0.
- Tie and threshold: src4 and src9 both pending at prio 6; thr0=6 → id0=0; thr0=5 → id0=4; claim0 → next cycle id0=9.
- Dual claim: both targets enabled for src7 only, claim0=claim1=1 in the same cycle → src7 BUSY, next cycle id0=id1=0; complete1 with id 7 → src7 IDLE and re-pends if src7 is still high.
- Edge counting: 5 rising edges on src2 (el=1) while BUSY, then complete → exactly 3 further claim/complete rounds, then id=0.
- Bad complete: complete0 with complete_id=0, then 12 (not BUSY), then 15 while IDLE → no state change, no spurious ireq.
- Reset mid-operation: src5 claimed and src6 pending, rst=1 for one cycle → ireq=0, id=0 next cycle; src6 (level, still high) re-requests two cycles after rst deasserts.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared types and helpers for the multi-target PLIC core and its gateways.
package plic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    BUSY = 2'd2
  } gw_state_e;

  // Ceiling log2, used for constant widths only.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Low bit of slice idx inside a flattened vector of width-wide fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/plic_gateway_mt.sv
// One interrupt gateway: level/edge capture, saturating edge counter and
// IDLE/PEND/BUSY handshake state. The mode input is re-sampled only while IDLE.
module plic_gateway_mt
  import plic_pkg::*;
#(
  parameter int unsigned MAX_EDGE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic el,
  input  logic claim,
  input  logic complete,
  output logic ip
);

  localparam int unsigned     CNT_W   = clog2(MAX_EDGE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_EDGE);

  gw_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_q, src_d;
  logic             mode_q, mode_d;
  logic             edge_mode;
  logic             rise;
  logic             inc;
  logic             dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src;
    mode_d    = mode_q;
    dec       = 1'b0;
    edge_mode = (state_q == IDLE) ? el : mode_q;
    rise      = src & ~src_q;
    inc       = edge_mode & rise;

    unique case (state_q)
      IDLE: begin
        mode_d = el;
        if (el) begin
          if (cnt_q != '0) begin
            state_d = PEND;
            dec     = 1'b1;
          end
        end else if (src) begin
          state_d = PEND;
        end
      end
      PEND:    if (claim) state_d = BUSY;
      BUSY:    if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A simultaneous edge and dequeue cancel, even at saturation.
    if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign ip = (state_q == PEND);

endmodule

// File: rtl/plic_core_mt.sv
// Multi-target PLIC core: NSRC gateways feeding one registered priority arbiter
// per target context. Source ID n (1..NSRC) uses bit n-1 of every per-source vector.
module plic_core_mt
  import plic_pkg::*;
#(
  parameter int unsigned NSRC     = 15,
  parameter int unsigned PRIO_W   = 3,
  parameter int unsigned NTGT     = 2,
  parameter int unsigned MAX_EDGE = 3,
  parameter int unsigned IDW      = clog2(NSRC + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        src,
  input  logic [NSRC-1:0]        el,
  input  logic [NSRC*PRIO_W-1:0] ipriority,
  input  logic [NTGT*NSRC-1:0]   ie,
  input  logic [NTGT*PRIO_W-1:0] threshold,
  input  logic [NTGT-1:0]        claim,
  input  logic [NTGT-1:0]        complete,
  input  logic [NTGT*IDW-1:0]    complete_id,
  output logic [NTGT-1:0]        ireq,
  output logic [NTGT*IDW-1:0]    id
);

  logic [NSRC-1:0]              ip;
  logic [NSRC-1:0]              claim_src;
  logic [NSRC-1:0]              complete_src;
  logic [NSRC-1:0][PRIO_W-1:0]  prio;
  logic [NTGT-1:0][PRIO_W-1:0]  thr;
  logic [NTGT-1:0][IDW-1:0]     cid;
  logic [NTGT-1:0][IDW-1:0]     id_q, id_d;
  logic [NTGT-1:0]              ireq_q, ireq_d;

  assign prio = ipriority;
  assign thr  = threshold;
  assign cid  = complete_id;

  for (genvar s = 0; s < NSRC; s++) begin : g_gw
    plic_gateway_mt #(
      .MAX_EDGE(MAX_EDGE)
    ) u_gw (
      .clk     (clk),
      .rst     (rst),
      .src     (src[s]),
      .el      (el[s]),
      .claim   (claim_src[s]),
      .complete(complete_src[s]),
      .ip      (ip[s])
    );
  end

  // Every claimer of one ID has the same effect, so lowest-index priority is implicit.
  always_comb begin
    claim_src    = '0;
    complete_src = '0;
    for (int unsigned t = 0; t < NTGT; t++) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (claim[t] && (id_q[t] == IDW'(s + 1))) claim_src[s] = 1'b1;
        if (complete[t] && (cid[t] == IDW'(s + 1))) complete_src[s] = 1'b1;
      end
    end
  end

  for (genvar t = 0; t < NTGT; t++) begin : g_arb
    logic [NSRC-1:0]   ie_t;
    logic [IDW-1:0]    win_id;
    logic [PRIO_W-1:0] win_prio;

    assign ie_t = ie[slice_lo(t, NSRC) +: NSRC];

    // Strict compare while scanning upward keeps the lowest ID on ties.
    always_comb begin
      win_id   = '0;
      win_prio = '0;
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (ip[s] && ie_t[s] && !claim_src[s] && (prio[s] > thr[t]) &&
            ((win_id == '0) || (prio[s] > win_prio))) begin
          win_id   = IDW'(s + 1);
          win_prio = prio[s];
        end
      end
    end

    assign id_d[t]   = win_id;
    assign ireq_d[t] = (win_id != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q   <= '0;
      ireq_q <= '0;
    end else begin
      id_q   <= id_d;
      ireq_q <= ireq_d;
    end
  end

  assign id   = id_q;
  assign ireq = ireq_q;

endmodule
